prio_arb: RTL and testbench

// - Round-robin arbiter built around the MSB-first priority pick. It shares one resource among N requesters.
// - A requester raises req[i] and holds it for the whole transaction. The arbiter issues a registered one-hot grant.
// - The grant stays with that requester until it drops req[i]. Priority then rotates so the last winner becomes lowest.
// - Sits in front of shared buses, memory ports and similar single-owner resources.
//

---
 rtl/prio_arb.sv | 171 +++++++++++++++++
 tb/tb_prio_arb.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/prio_arb.sv
// prio_arb: round-robin arbiter built on an MSB-first priority pick.
// One owner at a time gets a registered one-hot grant and keeps it until it
// drops its request. Priority then rotates so the last owner becomes lowest.
//
// Optional feature macro: PRIO_ARB_TIMEOUT_EN. When it is defined, an owner
// that has held the grant for TMAX cycles loses it to any other pending
// requester.
//
// Ports:
//   clk       in   1          clock, all state on the rising edge
//   nreset    in   1          asynchronous active-low reset
//   req       in   N          request vector, bit i = requester i
//   grant     out  N          registered one-hot grant, zero when idle
//   grant_id  out  clog2(N)   index of the granted bit, zero when idle
//   busy      out  1          grant != 0
module prio_arb #(
  parameter int unsigned N    = 8,
  parameter int unsigned TMAX = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
);

  localparam int unsigned IW = $clog2(N);

  // Reject unusable parameter values at elaboration.
  if (N < 2 || TMAX < 1) begin : g_param_chk
    $error("prio_arb: requires N >= 2 and TMAX >= 1");
  end

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   id_q, id_d;
  logic [IW-1:0]   last_q, last_d;
  logic            busy_q, busy_d;

  logic            arb_en_c;
  logic [N-1:0]    cand_c;
  logic [IW-1:0]   base_c;
  logic [IW-1:0]   win_c;

`ifdef PRIO_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMAX + 1);
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            tmo_c;
`endif

  // Highest set bit among those strictly below base l; if none, highest set bit overall.
  function automatic logic [IW-1:0] pick_idx(input logic [N-1:0] v, input logic [IW-1:0] l);
    logic [N-1:0]  hi;
    logic [N-1:0]  src;
    logic [IW-1:0] idx;
    hi  = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(l)) hi[i] = v[i];
    end
    src = (hi != '0) ? hi : v;
    for (int i = 0; i < N; i++) begin
      if (src[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  // Next-state and next-output decode.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    id_d     = id_q;
    busy_d   = busy_q;
    last_d   = last_q;
    arb_en_c = 1'b0;
    cand_c   = req;
    base_c   = last_q;
    win_c    = '0;
`ifdef PRIO_ARB_TIMEOUT_EN
    tmo_c    = (tcnt_q == TW'(TMAX)) && ((req & ~grant_q) != '0);
`endif

    case (state_q)
      ST_IDLE: begin
        if (req != '0) arb_en_c = 1'b1;
      end
      ST_OWNED: begin
        if (!req[id_q]) begin
          // Release: rotate on the departing owner and re-arbitrate on this edge.
          last_d = id_q;
          base_c = id_q;
          if (req != '0) begin
            arb_en_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            id_d    = '0;
            busy_d  = 1'b0;
          end
        end
`ifdef PRIO_ARB_TIMEOUT_EN
        else if (tmo_c) begin
          // Revoke: the current owner is excluded from this pick only.
          last_d   = id_q;
          base_c   = id_q;
          cand_c   = req & ~grant_q;
          arb_en_c = 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        id_d    = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (arb_en_c) begin
      win_c   = pick_idx(cand_c, base_c);
      state_d = ST_OWNED;
      grant_d = N'(1) << win_c;
      id_d    = win_c;
      busy_d  = 1'b1;
    end

`ifdef PRIO_ARB_TIMEOUT_EN
    // Hold counter: clears on each new grant, saturates at TMAX while owned.
    tcnt_d = tcnt_q;
    if (arb_en_c) begin
      tcnt_d = '0;
    end else if (state_q == ST_OWNED && tcnt_q != TW'(TMAX)) begin
      tcnt_d = tcnt_q + TW'(1);
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= '0;
      busy_q  <= 1'b0;
`ifdef PRIO_ARB_TIMEOUT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
`ifdef PRIO_ARB_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign grant_id = id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_prio_arb.sv
// Directed bench for prio_arb (N = 8, TMAX = 4).
module tb_prio_arb;

  logic       clk;
  logic       nreset;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       busy;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] req_edge;

  prio_arb #(
    .N    (8),
    .TMAX (4)
  ) u_dut (
    .clk      (clk),
    .nreset   (nreset),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request vector seen by the DUT at each rising edge.
  always @(posedge clk) req_edge <= req;

  // Structural invariants, checked between edges while out of reset.
  always @(negedge clk) begin
    if (nreset) begin
      logic [2:0] exp_id;
      exp_id = '0;
      for (int i = 0; i < 8; i++) begin
        if (grant[i]) exp_id = 3'(i);
      end
      check("onehot", 32'($onehot0(grant)), 32'd1);
      check("busy_or", 32'(busy), 32'(|grant));
      check("id_match", 32'(grant_id), 32'(exp_id));
      check("grant_req", 32'(grant & ~req_edge), 32'd0);
    end
  end

  initial begin
    logic [7:0] cur;
    logic [7:0] rot_exp [8];

    // T1: reset with all requests pending
    nreset = 1'b0;
    req    = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_id", 32'(grant_id), 32'd0);
    #2 nreset = 1'b1;
    tick();
    check("t1_grant", 32'(grant), 32'h80);
    check("t1_id", 32'(grant_id), 32'd7);
    check("t1_busy", 32'(busy), 32'd1);

`ifndef PRIO_ARB_TIMEOUT_EN
    // T2: owner 7 holds while requester 3 waits
    req = 8'h88;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("t2_hold", 32'(grant), 32'h80);
    end
`endif

    // T3: rotation, each owner dropping for one cycle
    rot_exp = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    cur = 8'h80;
    for (int s = 0; s < 8; s++) begin
      req = ~cur;
      tick();
      check("t3_rot", 32'(grant), 32'(rot_exp[s]));
      cur = rot_exp[s];
    end

    // T4: fairness, released owner becomes lowest
    req = 8'h81;
    tick();
    check("t4_hold7", 32'(grant), 32'h80);
    req = 8'h01;
    tick();
    check("t4_to0", 32'(grant), 32'h01);
    req = 8'h81;
    tick();
    check("t4_hold0", 32'(grant), 32'h01);
    req = 8'h80;
    tick();
    check("t4_back7", 32'(grant), 32'h80);

    // Idle return, then pick rotated on last = 7
    req = 8'h00;
    tick();
    check("idle_grant", 32'(grant), 32'h00);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_id", 32'(grant_id), 32'd0);
    req = 8'h11;
    tick();
    check("rot_pick", 32'(grant), 32'h10);
    check("rot_id", 32'(grant_id), 32'd4);

    // T6: async reset mid-grant clears rotation state (last = 4 before reset)
    req = 8'h01;
    tick();
    check("t6_pre", 32'(grant), 32'h01);
    req = 8'h11;
    tick();
    check("t6_hold", 32'(grant), 32'h01);
    #2 nreset = 1'b0;
    #1;
    check("t6_async", 32'(grant), 32'h00);
    check("t6_busy", 32'(busy), 32'd0);
    #2 nreset = 1'b1;
    tick();
    check("t6_restart", 32'(grant), 32'h10);
    check("t6_id", 32'(grant_id), 32'd4);

`ifdef PRIO_ARB_TIMEOUT_EN
    // T5: revoke after the hold limit, sole requester keeps the grant
    req = 8'h00;
    tick();
    check("t5_idle", 32'(grant), 32'h00);
    req = 8'h0C;
    tick();
    check("t5_first", 32'(grant), 32'h08);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t5_hold", 32'(grant), 32'h08);
    end
    tick();
    check("t5_revoke", 32'(grant), 32'h04);
    req = 8'h08;
    tick();
    check("t5_alone", 32'(grant), 32'h08);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t5_forever", 32'(grant), 32'h08);
    end
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Run-length bound.
  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
